// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared decode definitions for the D->E control path: opcodes, select encodings, E-register layout.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: opcode localparams, ResultSrc/ImmSrc/ALUOp enums, ctrl_t, counter width helper.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    RES_ALU = 3'b000,
    RES_MEM = 3'b001,
    RES_PC4 = 3'b010,
    RES_IMM = 3'b011,
    RES_MD  = 3'b100
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Everything that travels in the D->E register. ImmSrc is consumed in D and is not carried.
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
    logic        jump_reg;
    logic        alu_src;
    logic        src_a_src;
    logic        md_op;
    logic        illegal;
  } ctrl_t;

  // Counter width for the longest latency; floored at 1 so a single-cycle build still has a legal vector.
  function automatic int unsigned md_ctr_width(int unsigned mul_lat, int unsigned div_lat);
    int unsigned lmax;
    int unsigned w;
    lmax = (mul_lat > div_lat) ? mul_lat : div_lat;
    w    = $clog2(lmax);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_md_latency_ctr.sv
// Mul/div occupancy counter: loads L-1 when an M op enters E, then counts down to zero.
// Latency: busy rises the cycle after the load edge and stays high for L-1 cycles.
// Backpressure: busy is the hold/stall request; load is only expected while busy is low.
// Ports: clk, reset (sync, active-high), load, sel_div (funct3[2] of the loading op), busy.
module md_latency_ctr
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic sel_div,
  output logic busy
);

  localparam int unsigned W = md_ctr_width(MUL_LATENCY, DIV_LATENCY);
  localparam logic [W-1:0] MUL_INIT = W'(MUL_LATENCY - 1);
  localparam logic [W-1:0] DIV_INIT = W'(DIV_LATENCY - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= sel_div ? DIV_INIT : MUL_INIT;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A latency of 1 loads zero, so busy never rises for that op class.
  assign busy = (cnt != '0);

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Main-control decoder for the RV32IM pipeline plus the D->E control register with flush/bubble.
// Latency: ImmSrcD combinational; E controls 1 cycle after D.
// Backpressure: MdBusy holds E (flush ignored) and requests an F/D stall while a mul/div is in E.
// Ports: clk, reset, InstrD, FlushE in; ImmSrcD, E controls, MdOpE, IllegalE, MdBusy out.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int ENABLE_M    = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        FlushE,
  output logic [2:0]  ImmSrcD,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JumpRegE,
  output logic        ALUSrcE,
  output logic        SrcAsrcE,
  output logic [2:0]  ResultSrcE,
  output logic [1:0]  ALUOpE,
  output logic        MdOpE,
  output logic        IllegalE,
  output logic        MdBusy
);

  logic [6:0] opcode;
  logic       funct7_0;
  logic       funct3_2;
  ctrl_t      dec;
  imm_src_e   imm_src;
  ctrl_t      e_q;
  logic       md_load;
  logic       unused_instr_bits;

  assign opcode   = InstrD[6:0];
  assign funct7_0 = InstrD[25];
  assign funct3_2 = InstrD[14];
  assign unused_instr_bits = ^{InstrD[31:26], InstrD[24:15], InstrD[13:7]};

  // Unknown opcodes fall through with all controls low, so they can never write state.
  always_comb begin
    dec     = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_STORE: begin
        imm_src       = IMM_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        if (funct7_0 && (ENABLE_M == 0)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOP_FUNCT;
          if (funct7_0) begin
            dec.result_src = RES_MD;
            dec.md_op      = 1'b1;
          end
        end
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        imm_src    = IMM_B;
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_BR;
      end
      OP_LUI: begin
        imm_src        = IMM_U;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        imm_src       = IMM_U;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.src_a_src = 1'b1;
      end
      OP_JAL: begin
        imm_src        = IMM_J;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
        dec.src_a_src  = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
        dec.jump_reg   = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign ImmSrcD = imm_src;

  // Busy outranks flush: the op in E must finish, and the hazard unit re-issues any flush it still needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else if (MdBusy) begin
      e_q <= e_q;
    end else if (FlushE) begin
      e_q <= '0;
    end else begin
      e_q <= dec;
    end
  end

  // Counter arms on exactly the edges where an M op actually lands in E.
  assign md_load = !MdBusy && !FlushE && dec.md_op;

  md_latency_ctr #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_md_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (md_load),
    .sel_div (funct3_2),
    .busy    (MdBusy)
  );

  assign RegWriteE  = e_q.reg_write;
  assign MemWriteE  = e_q.mem_write;
  assign BranchE    = e_q.branch;
  assign JumpE      = e_q.jump;
  assign JumpRegE   = e_q.jump_reg;
  assign ALUSrcE    = e_q.alu_src;
  assign SrcAsrcE   = e_q.src_a_src;
  assign ResultSrcE = e_q.result_src;
  assign ALUOpE     = e_q.alu_op;
  assign MdOpE      = e_q.md_op;
  assign IllegalE   = e_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: one M-enabled instance and one ENABLE_M=0 instance on shared inputs.
// Expected E vectors are queued as stimulus is driven and compared on the following falling edge.
module tb_decode_ctrl_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic        FlushE;

  logic [2:0] ImmSrcD, ResultSrcE;
  logic [1:0] ALUOpE;
  logic RegWriteE, MemWriteE, BranchE, JumpE, JumpRegE, ALUSrcE, SrcAsrcE, MdOpE, IllegalE, MdBusy;

  logic [2:0] n_ImmSrcD, n_ResultSrcE;
  logic [1:0] n_ALUOpE;
  logic n_RegWriteE, n_MemWriteE, n_BranchE, n_JumpE, n_JumpRegE, n_ALUSrcE, n_SrcAsrcE;
  logic n_MdOpE, n_IllegalE, n_MdBusy;

  decode_ctrl_pipe #(.ENABLE_M(1), .MUL_LATENCY(2), .DIV_LATENCY(32)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JumpRegE(JumpRegE), .ALUSrcE(ALUSrcE), .SrcAsrcE(SrcAsrcE), .ResultSrcE(ResultSrcE),
    .ALUOpE(ALUOpE), .MdOpE(MdOpE), .IllegalE(IllegalE), .MdBusy(MdBusy)
  );

  decode_ctrl_pipe #(.ENABLE_M(0), .MUL_LATENCY(2), .DIV_LATENCY(32)) dut_nom (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE), .ImmSrcD(n_ImmSrcD),
    .RegWriteE(n_RegWriteE), .MemWriteE(n_MemWriteE), .BranchE(n_BranchE), .JumpE(n_JumpE),
    .JumpRegE(n_JumpRegE), .ALUSrcE(n_ALUSrcE), .SrcAsrcE(n_SrcAsrcE), .ResultSrcE(n_ResultSrcE),
    .ALUOpE(n_ALUOpE), .MdOpE(n_MdOpE), .IllegalE(n_IllegalE), .MdBusy(n_MdBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector layout: rw, rs[2:0], mw, br, aop[1:0], j, jr, alusrc, srca, md, ill, busy.
  function automatic logic [14:0] mk(logic rw, logic [2:0] rs, logic mw, logic br, logic [1:0] aop,
                                     logic j, logic jr, logic asrc, logic sa, logic md, logic ill,
                                     logic busy);
    return {rw, rs, mw, br, aop, j, jr, asrc, sa, md, ill, busy};
  endfunction

  typedef struct {
    logic [14:0] e;
    logic        cn;
    logic [14:0] n;
  } sb_t;

  sb_t   sb_q[$];
  string tag_q[$];

  logic [14:0] obs, obs_nom;
  assign obs = {RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUOpE, JumpE, JumpRegE,
                ALUSrcE, SrcAsrcE, MdOpE, IllegalE, MdBusy};
  assign obs_nom = {n_RegWriteE, n_ResultSrcE, n_MemWriteE, n_BranchE, n_ALUOpE, n_JumpE,
                    n_JumpRegE, n_ALUSrcE, n_SrcAsrcE, n_MdOpE, n_IllegalE, n_MdBusy};

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t   s;
      string t;
      s = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {17'd0, obs}, {17'd0, s.e});
      if (s.cn) chk({t, "_nom"}, {17'd0, obs_nom}, {17'd0, s.n});
    end
  end

  // Drive one cycle; exp is the E state (and MdBusy) expected after the coming rising edge.
  task automatic cyc(input logic [31:0] instr, input logic flush, input logic rst,
                     input logic [14:0] exp, input int exp_imm, input string tag,
                     input logic cn = 1'b0, input logic [14:0] exp_nom = '0);
    sb_t s;
    InstrD = instr;
    FlushE = flush;
    reset  = rst;
    #1;
    if (exp_imm >= 0) chk({tag, "_imm"}, {29'd0, ImmSrcD}, exp_imm);
    @(posedge clk);
    s.e = exp;
    s.cn = cn;
    s.n = exp_nom;
    sb_q.push_back(s);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0050A023;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_LUI   = 32'h000012B7;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_ZERO  = 32'h00000000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [14:0] v_zero, v_addi, v_add, v_lw, v_sw, v_beq, v_lui, v_auipc, v_jal, v_jalr, v_ill;
    logic [14:0] v_md_b, v_md;
    v_zero  = '0;
    v_addi  = mk(1, 3'b000, 0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0);
    v_add   = mk(1, 3'b000, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    v_lw    = mk(1, 3'b001, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    v_sw    = mk(0, 3'b000, 1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    v_beq   = mk(0, 3'b000, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    v_lui   = mk(1, 3'b011, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    v_auipc = mk(1, 3'b000, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0);
    v_jal   = mk(1, 3'b010, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0);
    v_jalr  = mk(1, 3'b010, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
    v_ill   = mk(0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    v_md    = mk(1, 3'b100, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 0);
    v_md_b  = mk(1, 3'b100, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 1);

    InstrD = I_ADDI;
    FlushE = 1'b0;
    reset  = 1'b1;

    // Reset state, then one of every legal opcode class.
    cyc(I_ADDI, 0, 1, v_zero, -1, "reset0", 1, v_zero);
    cyc(I_ADDI, 0, 1, v_zero, -1, "reset1", 1, v_zero);
    cyc(I_ADDI,  0, 0, v_addi,  0, "addi");
    cyc(I_LW,    0, 0, v_lw,    0, "lw");
    cyc(I_SW,    0, 0, v_sw,    1, "sw");
    cyc(I_BEQ,   0, 0, v_beq,   2, "beq");
    cyc(I_LUI,   0, 0, v_lui,   4, "lui");
    cyc(I_AUIPC, 0, 0, v_auipc, 4, "auipc");
    cyc(I_JAL,   0, 0, v_jal,   3, "jal");
    cyc(I_JALR,  0, 0, v_jalr,  0, "jalr");
    cyc(I_ADD,   0, 0, v_add,   0, "add");
    cyc(I_ZERO,  0, 0, v_ill,   0, "illegal");
    cyc(I_JAL,   1, 0, v_zero,  3, "flush_jal");

    // DIV holds E for 32 cycles with MdBusy high for the first 31; a flush mid-busy is ignored.
    cyc(I_DIV, 0, 0, v_md_b, 0, "div_load");
    for (int i = 0; i < 30; i++) cyc(I_ADD, (i == 5), 0, v_md_b, -1, "div_busy");
    cyc(I_ADD, 0, 0, v_md,  -1, "div_last");
    cyc(I_ADD, 0, 0, v_add, -1, "div_release");

    // Back-to-back MULs at latency 2: busy 1,0,1,0 with each op in E for 2 cycles.
    cyc(I_MUL, 0, 0, v_md_b, 0, "mul1_load");
    cyc(I_MUL, 0, 0, v_md,   0, "mul1_last");
    cyc(I_MUL, 0, 0, v_md_b, 0, "mul2_load");
    cyc(I_ADD, 0, 0, v_md,   0, "mul2_last");
    cyc(I_ADD, 0, 0, v_add,  0, "mul2_release");

    // Reset at busy cycle 10 clears E and drops MdBusy immediately after.
    cyc(I_DIV, 0, 0, v_md_b, -1, "rdiv_load");
    for (int i = 0; i < 9; i++) cyc(I_ADD, 0, 0, v_md_b, -1, "rdiv_busy");
    cyc(I_ADD, 0, 1, v_zero, -1, "rdiv_reset");
    cyc(I_ADD, 0, 0, v_add,  -1, "rdiv_after");

    // Without the M extension a MUL is illegal and never occupies E.
    cyc(I_MUL, 0, 0, v_md_b, 0, "nom_mul", 1, v_ill);
    cyc(I_ADD, 0, 0, v_md,   0, "nom_add0", 1, v_add);
    cyc(I_ADD, 0, 0, v_add,  0, "nom_add1", 1, v_add);

    @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered main-control decoder for the 5-stage RV32IM pipeline. It decodes the Decode-stage instruction into control fields, drives `ImmSrcD` combinationally to the extender, and owns the D→E control register with flush and bubble handling. It adds three things to the combinational decoder:

- illegal-opcode detection;
- a build-time M-extension enable;
- a multi-cycle mul/div occupancy counter that holds Execute and raises a stall to the hazard unit.

## Interface
Parameters:
- `ENABLE_M`, 1 — M-extension decode enabled; 0 makes funct7[0]=1 R-type ops illegal.
- `MUL_LATENCY`, 2 — cycles a mul-class op (funct3[2]=0) occupies E; ≥1.
- `DIV_LATENCY`, 32 — cycles a div/rem op (funct3[2]=1) occupies E; ≥1.

Ports:
- `clk` in 1 — clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `InstrD` in 32 — Decode-stage instruction.
- `FlushE` in 1 — hazard unit: load a bubble into E.
- `ImmSrcD` out 3 — combinational immediate select.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `JumpRegE`, `ALUSrcE`, `SrcAsrcE` out 1 each — registered controls.
- `ResultSrcE` out 3 — registered result-mux select.
- `ALUOpE` out 2 — registered ALU-decoder class.
- `MdOpE` out 1 — E holds an M-extension op.
- `IllegalE` out 1 — E holds an illegal instruction.
- `MdBusy` out 1 — combinational; E is held and F/D must stall.

## Operation
Decode table. Field order is RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, SrcAsrc, JumpReg.
- Load 0000011: 1,000,1,0,001,0,00,0,0,0
- Store 0100011: 0,001,1,1,000,0,00,0,0,0
- R-type 0110011: 1,000,0,0,000,0,10,0,0,0
- R-type with funct7[0]=1 and `ENABLE_M`=1: same as R-type but ResultSrc=100 and MdOp=1.
- I-ALU 0010011: 1,000,1,0,000,0,10,0,0,0
- Branch 1100011: 0,010,0,0,000,1,01,0,0,0
- LUI 0110111: 1,100,1,0,011,0,00,0,0,0
- AUIPC 0010111: 1,100,1,0,000,0,00,0,1,0
- JAL 1101111: 1,011,0,0,010,0,00,1,1,0
- JALR 1100111: 1,000,0,0,010,0,00,1,0,1

Other decode rules:
- `JumpRegE` is active-high and is 1 only for JALR.
- Illegal instruction = any other opcode, or an M op with `ENABLE_M`=0.
  - Decodes to all-zero controls with Illegal=1.
  - Never writes the register file or memory.

E register update, highest priority first:
1. `reset`: all E outputs 0 and counter 0.
2. `MdBusy`: hold all E outputs and ignore `FlushE`.
3. `FlushE`: bubble; all E outputs 0, including `IllegalE`.
4. Otherwise: load the decoded D controls.

Mul/div occupancy counter:
- Width is $clog2(max(MUL_LATENCY, DIV_LATENCY)).
- On an edge that loads an M op into E, the counter loads L−1, where L is selected by `InstrD` funct3[2].
- While the counter is nonzero it decrements each edge.
- `MdBusy` = (counter ≠ 0).
- L=1 never asserts `MdBusy`.

## Timing
- Decode→E latency: 1 cycle.
- `ImmSrcD` has 0-cycle latency.
- Reset values: every registered output 0 and `MdBusy` 0 in the cycle after the `reset` edge.
- An M op latched at edge t:
  - `MdBusy` is high for cycles t..t+L−2.
  - It falls at edge t+L−1.
  - The op leaves E at edge t+L, so it occupies E for exactly L cycles.
- Back-to-back M ops: the second loads only after the first releases, so there are no gap cycles and the counter reloads on that edge.
- `FlushE` asserted together with `MdBusy` has no effect; the hazard unit re-asserts it if still needed.
- `reset` mid-busy: the counter and E clear on that edge, and `MdBusy` drops in the next cycle.
- `InstrD` is sampled only on a non-held edge; changes while `MdBusy` is high are ignored.

## Structure
- `ctrl_pkg` contains:
  - opcode localparams;
  - ResultSrc encodings (ALU=000, MEM=001, PC4=010, IMM=011, MD=100);
  - ImmSrc encodings (I=000, S=001, B=010, J=011, U=100);
  - packed struct `ctrl_t` for the E-register fields.
- Sub-module `md_latency_ctr`: the parameterised load/decrement counter producing `MdBusy`.
- Decode is a single `always_comb` case on opcode; the E register is a single `ctrl_t` flop.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093): at the next edge, RegWriteE=1, ALUSrcE=1, ALUOpE=10, ResultSrcE=000, others 0; `ImmSrcD`=000 immediately.
- DIV (funct7=0000001, funct3=100) with `DIV_LATENCY`=32: MdOpE=1, ResultSrcE=100, `MdBusy` high exactly 31 cycles; `InstrD` changed to ADD meanwhile loads only at edge 32.
- MUL immediately followed by another MUL with `MUL_LATENCY`=2: `MdBusy` pattern 1,0,1,0; each op occupies E 2 cycles.
- Opcode 0000000: IllegalE=1, all controls 0. With `ENABLE_M`=0, MUL gives IllegalE=1, `MdBusy` never asserts.
- `FlushE`=1 with JAL in D: E all zero. `FlushE` during DIV busy: ignored. `reset` at busy cycle 10: E cleared, `MdBusy`=0 next cycle.
- JALR vs JAL: JumpRegE=1 only for JALR. Both give JumpE=1 and ResultSrcE=010. SrcAsrcE=1 only for JAL and AUIPC.
